// File: rtl/branch_resolve_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | branch_resolve_pkg: shared widths, condition codes, FSM states    |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
package branch_resolve_pkg;

  localparam int BR_DSIZE  = 16;
  localparam int BR_CNT_W  = 3;
  localparam int BR_STAT_W = 16;

  localparam logic [2:0] BR_NEQ    = 3'b000;
  localparam logic [2:0] BR_EQ     = 3'b001;
  localparam logic [2:0] BR_GT     = 3'b010;
  localparam logic [2:0] BR_LT     = 3'b011;
  localparam logic [2:0] BR_GEQ    = 3'b100;
  localparam logic [2:0] BR_LEQ    = 3'b101;
  localparam logic [2:0] BR_OVF    = 3'b110;
  localparam logic [2:0] BR_UNCOND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } br_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | branch_cond_eval: condition code + flags [Z,V,N] -> taken         |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
module branch_cond_eval
  import branch_resolve_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flag_i,
  output logic       taken_o
);

  logic z, v, n;
  assign z = flag_i[2];
  assign v = flag_i[1];
  assign n = flag_i[0];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      BR_NEQ:    taken_o = ~z;
      BR_EQ:     taken_o = z;
      BR_GT:     taken_o = ~z & ~n;
      BR_LT:     taken_o = n;
      BR_GEQ:    taken_o = ~n;
      BR_LEQ:    taken_o = z | n;
      BR_OVF:    taken_o = v;
      BR_UNCOND: taken_o = 1'b1;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | branch_resolve: branch resolution, PC redirect and flush control  |
// | Optional BR_STATS_EN adds taken/not-taken counters. Rev 1.0       |
// +-----------------------------------------------------------------+
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DSIZE        = BR_DSIZE,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic [DSIZE-1:0] br_pc,
  input  logic [7:0]       br_offset,
  input  logic [2:0]       flag,
  input  logic             flag_pend,
  output logic             stall,
  output logic             redirect,
  output logic [DSIZE-1:0] target_pc,
  output logic             flush
`ifdef BR_STATS_EN
  ,
  output logic [BR_STAT_W-1:0] taken_cnt,
  output logic [BR_STAT_W-1:0] nottaken_cnt
`endif
);

  br_state_e            state_q, state_d;
  logic [2:0]           cond_q, cond_d;
  logic [DSIZE-1:0]     pc_q, pc_d;
  logic [7:0]           off_q, off_d;
  logic [DSIZE-1:0]     target_q, target_d;
  logic                 redirect_q, redirect_d;
  logic [BR_CNT_W-1:0]  cnt_q, cnt_d;

  logic                 in_wait, hazard, taken;
  logic [2:0]           eval_cond;
  logic [DSIZE-1:0]     eval_pc, eval_target;
  logic [7:0]           eval_off;

  // A stalled branch is evaluated from its captured copy; otherwise from the live inputs.
  assign in_wait     = (state_q == ST_WAIT);
  assign eval_cond   = in_wait ? cond_q : br_cond;
  assign eval_pc     = in_wait ? pc_q   : br_pc;
  assign eval_off    = in_wait ? off_q  : br_offset;
  assign eval_target = eval_pc + {{(DSIZE-8){eval_off[7]}}, eval_off};
  assign hazard      = br_valid & flag_pend & (br_cond != BR_UNCOND);

  branch_cond_eval u_eval (
    .cond_i  (eval_cond),
    .flag_i  (flag),
    .taken_o (taken)
  );

  always_comb begin
    state_d    = state_q;
    cond_d     = cond_q;
    pc_d       = pc_q;
    off_d      = off_q;
    target_d   = target_q;
    redirect_d = 1'b0;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hazard) begin
          stall   = 1'b1;
          cond_d  = br_cond;
          pc_d    = br_pc;
          off_d   = br_offset;
          state_d = ST_WAIT;
        end else if (br_valid && taken) begin
          state_d    = ST_FLUSH;
          redirect_d = 1'b1;
          target_d   = eval_target;
          cnt_d      = BR_CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (taken) begin
          state_d    = ST_FLUSH;
          redirect_d = 1'b1;
          target_d   = eval_target;
          cnt_d      = BR_CNT_W'(FLUSH_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cond_q     <= '0;
      pc_q       <= '0;
      off_q      <= '0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cond_q     <= cond_d;
      pc_q       <= pc_d;
      off_q      <= off_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      cnt_q      <= cnt_d;
    end
  end

  assign redirect  = redirect_q;
  assign target_pc = target_q;
  assign flush     = (state_q == ST_FLUSH);

`ifdef BR_STATS_EN
  logic                 resolve;
  logic [BR_STAT_W-1:0] tcnt_q, ncnt_q;

  // Wrong-path branches seen during FLUSH never resolve, so they are not counted.
  assign resolve = ((state_q == ST_IDLE) & br_valid & ~hazard) | in_wait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
      ncnt_q <= '0;
    end else if (resolve) begin
      if (taken && (tcnt_q != '1))       tcnt_q <= tcnt_q + 1'b1;
      else if (!taken && (ncnt_q != '1)) ncnt_q <= ncnt_q + 1'b1;
    end
  end

  assign taken_cnt    = tcnt_q;
  assign nottaken_cnt = ncnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_branch_resolve: randomized scoreboard bench for branch_resolve |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int DW    = 16;
  localparam int FC    = 2;
  localparam int MAXC  = 4096;
  localparam int NRAND = 1500;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_valid;
  logic [2:0]    br_cond;
  logic [DW-1:0] br_pc;
  logic [7:0]    br_offset;
  logic [2:0]    flag;
  logic          flag_pend;
  logic          stall, redirect, flush;
  logic [DW-1:0] target_pc;
`ifdef BR_STATS_EN
  logic [15:0]   taken_cnt, nottaken_cnt;
`endif

  always #5 clk = ~clk;

  branch_resolve #(.DSIZE(DW), .FLUSH_CYCLES(FC)) dut (
    .clk       (clk),
    .rst       (rst),
    .br_valid  (br_valid),
    .br_cond   (br_cond),
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .flag      (flag),
    .flag_pend (flag_pend),
    .stall     (stall),
    .redirect  (redirect),
    .target_pc (target_pc),
    .flush     (flush)
`ifdef BR_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
`endif
  );

  typedef struct {
    int          cyc;
    logic [15:0] tgt;
  } redir_t;

  redir_t      exp_q[$];
  bit          exp_stall [MAXC+16];
  bit          exp_flush [MAXC+16];
  int          cyc = 0;
  bit          run = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          free_at = 0;
  bit          wait_pend = 1'b0;
  logic [2:0]  w_cond;
  logic [15:0] w_tgt;
  int          m_taken = 0;
  int          m_nt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: condition truth table and target arithmetic straight from the rules.
  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] calc_tgt(input logic [15:0] pc, input logic [7:0] off);
    int so, t;
    so = off[7] ? int'(off) - 256 : int'(off);
    t  = (int'(pc) + so + 65536) % 65536;
    return 16'(t);
  endfunction

  task automatic model_take(input logic [15:0] t);
    exp_q.push_back('{cyc + 1, t});
    for (int k = 1; k <= FC; k++) exp_flush[cyc + k] = 1'b1;
    free_at = cyc + 1 + FC;
    m_taken++;
  endtask

  task automatic model_step();
    if (cyc < free_at) return;
    if (wait_pend) begin
      exp_stall[cyc] = 1'b1;
      wait_pend = 1'b0;
      if (cond_true(w_cond, flag)) model_take(w_tgt);
      else m_nt++;
    end else if (br_valid) begin
      if (flag_pend && br_cond != BR_UNCOND) begin
        exp_stall[cyc] = 1'b1;
        wait_pend = 1'b1;
        w_cond = br_cond;
        w_tgt  = calc_tgt(br_pc, br_offset);
      end else if (cond_true(br_cond, flag)) begin
        model_take(calc_tgt(br_pc, br_offset));
      end else begin
        m_nt++;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [15:0] pc,
                       input logic [7:0] off, input logic [2:0] f, input logic p);
    @(posedge clk);
    #1;
    cyc++;
    br_valid  = wait_pend ? 1'b0 : v;
    br_cond   = c;
    br_pc     = pc;
    br_offset = off;
    flag      = f;
    flag_pend = p;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 16'h0, 8'h0, 3'd0, 1'b0);
  endtask

  // Monitor: pops the expected redirect whose cycle has come and checks every cycle.
  initial begin
    redir_t e;
    forever begin
      @(negedge clk);
      if (run && rst) begin
        check("stall", stall, exp_stall[cyc]);
        check("flush", flush, exp_flush[cyc]);
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          check("redirect", redirect, 1);
          if (redirect) check("target_pc", target_pc, e.tgt);
        end else begin
          check("no_redirect", redirect, 0);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; br_valid = 1'b0; br_cond = 3'd0; br_pc = '0;
    br_offset = '0; flag = 3'd0; flag_pend = 1'b0;
    #2;
    check("rst_stall", stall, 0);
    check("rst_redirect", redirect, 0);
    check("rst_flush", flush, 0);
    check("rst_target", target_pc, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    run = 1'b1;

    drive(1, BR_EQ, 16'h0010, 8'h05, 3'b100, 0);
    idle(3);
    drive(1, BR_NEQ, 16'h0030, 8'h07, 3'b100, 0);
    drive(1, BR_EQ, 16'h0020, 8'hFE, 3'b100, 0);
    idle(3);
    drive(1, BR_LT, 16'h0100, 8'h10, 3'b000, 1);
    drive(0, BR_EQ, 16'h0000, 8'h00, 3'b001, 0);
    idle(3);
    drive(1, BR_UNCOND, 16'hFFFF, 8'h01, 3'b000, 0);
    idle(3);
    drive(1, BR_UNCOND, 16'h0000, 8'hFF, 3'b000, 0);
    idle(3);
    drive(1, BR_GEQ, 16'h0200, 8'h80, 3'b000, 0);
    drive(1, BR_UNCOND, 16'h0400, 8'h11, 3'b000, 0);
    drive(1, BR_UNCOND, 16'h0500, 8'h22, 3'b000, 0);
    idle(2);
    drive(1, BR_UNCOND, 16'h0600, 8'h03, 3'b000, 1);
    idle(3);
    drive(0, BR_EQ, 16'h0700, 8'h03, 3'b100, 1);
    idle(2);

    drive(1, BR_UNCOND, 16'h1234, 8'h10, 3'b000, 0);
    idle(2);
    #1;
    rst = 1'b0;
    #1;
    check("arst_stall", stall, 0);
    check("arst_redirect", redirect, 0);
    check("arst_flush", flush, 0);
    check("arst_target", target_pc, 0);
    exp_q.delete();
    for (int k = 0; k <= FC + 1; k++) begin
      exp_flush[cyc + k] = 1'b0;
      exp_stall[cyc + k] = 1'b0;
    end
    free_at = 0; wait_pend = 1'b0; m_taken = 0; m_nt = 0;
    idle(1);
    #1;
    rst = 1'b1;
    drive(1, BR_OVF, 16'h0040, 8'h04, 3'b010, 0);
    idle(3);

    for (int i = 0; i < NRAND; i++)
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            8'($urandom), 3'($urandom), ($urandom_range(0, 2) == 0));
    idle(6);

`ifdef BR_STATS_EN
    check("taken_cnt", taken_cnt, (m_taken > 65535) ? 65535 : m_taken);
    check("nottaken_cnt", nottaken_cnt, (m_nt > 65535) ? 65535 : m_nt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
